// File: rtl/des_pkg.sv
// Shared types and helpers for the DES/3DES schedule controller.
// States, block width and the EDE key-order helpers.
package des_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_IP     = 3'd2,
        ST_KEYGEN = 3'd3,
        ST_ROUND  = 3'd4,
        ST_SWAP   = 3'd5,
        ST_FP     = 3'd6,
        ST_DONE   = 3'd7
    } des_sched_state_t;

    localparam int DES_BLOCK_W = 64;

    // EDE: encrypt runs E-D-E, decrypt runs D-E-D.
    function automatic logic ede_key_rev(
        input logic       mode,
        input logic [1:0] pass
    );
        return mode ? pass[0] : ~pass[0];
    endfunction

    // Decrypt walks the key bundle backwards.
    function automatic logic [1:0] ede_key_sel(
        input logic       mode,
        input logic [1:0] pass,
        input logic [1:0] last
    );
        return mode ? pass : 2'(last - pass);
    endfunction

endpackage

// File: rtl/des_sched_ctrl_if.sv
// Handshake and control bundle of the DES schedule controller.
// abort exists only when DES_SCHED_ABORT_EN is defined.
interface des_sched_ctrl_if #(
    parameter int ROUNDS = 16
) ();

    localparam int RW = $clog2(ROUNDS);

    logic          blk_ready;
    logic          encrypt;
    logic          out_ack;
`ifdef DES_SCHED_ABORT_EN
    logic          abort;
`endif
    logic          load_blk;
    logic          ip_en;
    logic          round_en;
    logic [RW-1:0] round_idx;
    logic [1:0]    pass_idx;
    logic [1:0]    key_sel;
    logic          key_reverse;
    logic          swap_en;
    logic          fp_en;
    logic          data_valid;
    logic          busy;

    modport master (
        input  blk_ready,
        input  encrypt,
        input  out_ack,
`ifdef DES_SCHED_ABORT_EN
        input  abort,
`endif
        output load_blk,
        output ip_en,
        output round_en,
        output round_idx,
        output pass_idx,
        output key_sel,
        output key_reverse,
        output swap_en,
        output fp_en,
        output data_valid,
        output busy
    );

    modport slave (
        output blk_ready,
        output encrypt,
        output out_ack,
`ifdef DES_SCHED_ABORT_EN
        output abort,
`endif
        input  load_blk,
        input  ip_en,
        input  round_en,
        input  round_idx,
        input  pass_idx,
        input  key_sel,
        input  key_reverse,
        input  swap_en,
        input  fp_en,
        input  data_valid,
        input  busy
    );

endinterface

// File: rtl/des_round_counter.sv
// Round and pass counters with terminal flags.
// The pass advances (round wraps to 0) only after the last round.
module des_round_counter #(
    parameter int ROUNDS     = 16,
    parameter int NUM_PASSES = 1,
    parameter int RW         = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [RW-1:0] round_o,
    output logic [1:0]    pass_o,
    output logic          last_round_o,
    output logic          last_pass_o
);

    logic [RW-1:0] round_q;
    logic [1:0]    pass_q;

    assign last_round_o = (round_q == RW'(ROUNDS - 1));
    assign last_pass_o  = (pass_q == 2'(NUM_PASSES - 1));
    assign round_o      = round_q;
    assign pass_o       = pass_q;

    // Step the round; wrap into the next pass; hold at the very end.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            round_q <= '0;
            pass_q  <= '0;
        end else if (clr_i) begin
            round_q <= '0;
            pass_q  <= '0;
        end else if (adv_i) begin
            if (!last_round_o) begin
                round_q <= round_q + 1'b1;
            end else if (!last_pass_o) begin
                round_q <= '0;
                pass_q  <= pass_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/des_sched_ctrl.sv
// DES/3DES schedule controller: load, IP, rounds, swaps, FP, done.
// Optional abort input enabled by DES_SCHED_ABORT_EN.
module des_sched_ctrl
    import des_pkg::*;
#(
    parameter int ROUNDS        = 16,
    parameter int NUM_PASSES    = 1,
    parameter int KEYGEN_CYCLES = 1
) (
    input logic              clk,
    input logic              n_rst,
    des_sched_ctrl_if.master bus
);

    localparam int         RW   = $clog2(ROUNDS);
    localparam logic [1:0] LAST = 2'(NUM_PASSES - 1);
    localparam logic [1:0] KW   = 2'(KEYGEN_CYCLES - 1);

    if (!(NUM_PASSES == 1 || NUM_PASSES == 3)) begin : g_bad_passes
        $error("NUM_PASSES must be 1 or 3");
    end
    if (ROUNDS < 2 || ROUNDS > 64) begin : g_bad_rounds
        $error("ROUNDS must be 2..64");
    end
    if (KEYGEN_CYCLES < 1 || KEYGEN_CYCLES > 4) begin : g_bad_kg
        $error("KEYGEN_CYCLES must be 1..4");
    end

    des_sched_state_t state_q;
    logic             mode_q;
    logic [1:0]       wait_q;
    logic             load_q;
    logic             ip_q;
    logic             round_en_q;
    logic             swap_q;
    logic             fp_q;
    logic             dv_q;
    logic             busy_q;
    logic [1:0]       ksel_q;
    logic             krev_q;

    logic [RW-1:0]    round_idx;
    logic [1:0]       pass_idx;
    logic [1:0]       pass_nxt;
    logic             last_round;
    logic             last_pass;
    logic             abort_act;
    logic             cnt_clr;
    logic             cnt_adv;

`ifdef DES_SCHED_ABORT_EN
    assign abort_act = bus.abort && (state_q != ST_IDLE);
`else
    assign abort_act = 1'b0;
`endif

    assign pass_nxt = pass_idx + 2'd1;
    assign cnt_adv  = (state_q == ST_ROUND) && !abort_act;
    assign cnt_clr  = abort_act
                   || ((state_q == ST_DONE) && bus.out_ack);

    des_round_counter #(
        .ROUNDS     (ROUNDS),
        .NUM_PASSES (NUM_PASSES),
        .RW         (RW)
    ) u_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clr_i        (cnt_clr),
        .adv_i        (cnt_adv),
        .round_o      (round_idx),
        .pass_o       (pass_idx),
        .last_round_o (last_round),
        .last_pass_o  (last_pass)
    );

    // Schedule FSM; strobes are registered alongside the state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            wait_q     <= '0;
            load_q     <= 1'b0;
            ip_q       <= 1'b0;
            round_en_q <= 1'b0;
            swap_q     <= 1'b0;
            fp_q       <= 1'b0;
            dv_q       <= 1'b0;
            busy_q     <= 1'b0;
            ksel_q     <= '0;
            krev_q     <= 1'b0;
        end else begin
            load_q     <= 1'b0;
            ip_q       <= 1'b0;
            round_en_q <= 1'b0;
            swap_q     <= 1'b0;
            fp_q       <= 1'b0;
            if (abort_act) begin
                state_q <= ST_IDLE;
                wait_q  <= '0;
                dv_q    <= 1'b0;
                busy_q  <= 1'b0;
                ksel_q  <= '0;
                krev_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (bus.blk_ready) begin
                            state_q <= ST_LOAD;
                            mode_q  <= bus.encrypt;
                            load_q  <= 1'b1;
                            busy_q  <= 1'b1;
                            ksel_q  <= ede_key_sel(bus.encrypt, 2'd0, LAST);
                            krev_q  <= ede_key_rev(bus.encrypt, 2'd0);
                        end
                    end
                    ST_LOAD: begin
                        state_q <= ST_IP;
                        ip_q    <= 1'b1;
                    end
                    ST_IP: begin
                        state_q <= ST_KEYGEN;
                        wait_q  <= '0;
                    end
                    ST_KEYGEN: begin
                        if (wait_q == KW) begin
                            state_q    <= ST_ROUND;
                            round_en_q <= 1'b1;
                            wait_q     <= '0;
                        end else begin
                            wait_q <= wait_q + 2'd1;
                        end
                    end
                    ST_ROUND: begin
                        if (!last_round) begin
                            state_q <= ST_KEYGEN;
                        end else if (!last_pass) begin
                            state_q <= ST_SWAP;
                            swap_q  <= 1'b1;
                            ksel_q  <= ede_key_sel(mode_q, pass_nxt, LAST);
                            krev_q  <= ede_key_rev(mode_q, pass_nxt);
                        end else begin
                            state_q <= ST_FP;
                            fp_q    <= 1'b1;
                        end
                    end
                    ST_SWAP: begin
                        state_q <= ST_KEYGEN;
                    end
                    ST_FP: begin
                        state_q <= ST_DONE;
                        dv_q    <= 1'b1;
                    end
                    ST_DONE: begin
                        if (bus.out_ack) begin
                            state_q <= ST_IDLE;
                            dv_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            ksel_q  <= '0;
                            krev_q  <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.load_blk    = load_q;
    assign bus.ip_en       = ip_q;
    assign bus.round_en    = round_en_q;
    assign bus.round_idx   = round_idx;
    assign bus.pass_idx    = pass_idx;
    assign bus.key_sel     = ksel_q;
    assign bus.key_reverse = krev_q;
    assign bus.swap_en     = swap_q;
    assign bus.fp_en       = fp_q;
    assign bus.data_valid  = dv_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_des_sched_ctrl.sv
// Bench for des_sched_ctrl: three configurations against a schedule model.
// Abort scenario runs when DES_SCHED_ABORT_EN is defined.
module tb_des_sched_ctrl;

    typedef struct packed {
        logic       load;
        logic       ip;
        logic       rnd;
        logic       swap;
        logic       fp;
        logic       dv;
        logic       busy;
        logic       krev;
        logic [1:0] ksel;
        logic [1:0] pidx;
        logic [7:0] ridx;
    } obs_t;

    logic clk;
    logic n_rst;
    logic blk [3];
    logic enc [3];
    logic ack [3];
`ifdef DES_SCHED_ABORT_EN
    logic abrt [3];
`endif
    obs_t obs [3];

    int checks = 0;
    int errors = 0;

    bit m_act [3];
    int m_t [3];
    bit m_mode [3];

    des_sched_ctrl_if #(.ROUNDS(16)) if0 ();
    des_sched_ctrl_if #(.ROUNDS(16)) if1 ();
    des_sched_ctrl_if #(.ROUNDS(4))  if2 ();

    des_sched_ctrl #(
        .ROUNDS(16), .NUM_PASSES(1), .KEYGEN_CYCLES(1)
    ) u0 (.clk(clk), .n_rst(n_rst), .bus(if0));

    des_sched_ctrl #(
        .ROUNDS(16), .NUM_PASSES(3), .KEYGEN_CYCLES(1)
    ) u1 (.clk(clk), .n_rst(n_rst), .bus(if1));

    des_sched_ctrl #(
        .ROUNDS(4), .NUM_PASSES(1), .KEYGEN_CYCLES(3)
    ) u2 (.clk(clk), .n_rst(n_rst), .bus(if2));

    assign if0.blk_ready = blk[0];
    assign if0.encrypt   = enc[0];
    assign if0.out_ack   = ack[0];
    assign if1.blk_ready = blk[1];
    assign if1.encrypt   = enc[1];
    assign if1.out_ack   = ack[1];
    assign if2.blk_ready = blk[2];
    assign if2.encrypt   = enc[2];
    assign if2.out_ack   = ack[2];
`ifdef DES_SCHED_ABORT_EN
    assign if0.abort = abrt[0];
    assign if1.abort = abrt[1];
    assign if2.abort = abrt[2];
`endif

    assign obs[0] = {if0.load_blk, if0.ip_en, if0.round_en,
                     if0.swap_en, if0.fp_en, if0.data_valid,
                     if0.busy, if0.key_reverse, if0.key_sel,
                     if0.pass_idx, 8'(if0.round_idx)};
    assign obs[1] = {if1.load_blk, if1.ip_en, if1.round_en,
                     if1.swap_en, if1.fp_en, if1.data_valid,
                     if1.busy, if1.key_reverse, if1.key_sel,
                     if1.pass_idx, 8'(if1.round_idx)};
    assign obs[2] = {if2.load_blk, if2.ip_en, if2.round_en,
                     if2.swap_en, if2.fp_en, if2.data_valid,
                     if2.busy, if2.key_reverse, if2.key_sel,
                     if2.pass_idx, 8'(if2.round_idx)};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int pr(input int i);
        return (i == 2) ? 4 : 16;
    endfunction
    function automatic int pn(input int i);
        return (i == 1) ? 3 : 1;
    endfunction
    function automatic int pk(input int i);
        return (i == 2) ? 3 : 1;
    endfunction
    function automatic int dv_t(input int i);
        return 3 + pn(i) * pr(i) * (pk(i) + 1) + pn(i) - 1;
    endfunction

    // Expected outputs t cycles into a block (t=0: LOAD visible).
    function automatic obs_t exp_obs(
        input int i, input bit act, input int t,
        input bit mode, output bit kp
    );
        obs_t e;
        int r, n, k, per, body, u, p, v;
        e = '0;
        kp = 1'b1;
        r = pr(i);
        n = pn(i);
        k = pk(i);
        per = r * (k + 1) + 1;
        body = n * r * (k + 1) + n - 1;
        if (act) begin
            e.busy = 1'b1;
            kp = 1'b0;
            if (t == 0) begin
                e.load = 1'b1;
            end else if (t == 1) begin
                e.ip = 1'b1;
            end else if (t - 2 < body) begin
                u = t - 2;
                p = u / per;
                v = u % per;
                if (v == r * (k + 1)) begin
                    e.swap = 1'b1;
                end else begin
                    kp = 1'b1;
                    e.rnd = ((v % (k + 1)) == k);
                    e.ridx = 8'(v / (k + 1));
                    e.pidx = 2'(p);
                    e.ksel = mode ? 2'(p) : 2'(n - 1 - p);
                    e.krev = mode ? p[0] : ~p[0];
                end
            end else if (t - 2 == body) begin
                e.fp = 1'b1;
            end else begin
                e.dv = 1'b1;
            end
        end
        return e;
    endfunction

    // Model state: which block is in flight and how far along.
    always @(posedge clk or negedge n_rst) begin
        for (int i = 0; i < 3; i++) begin
            if (!n_rst) begin
                m_act[i] <= 1'b0;
                m_t[i] <= 0;
            end else if (!m_act[i]) begin
                if (blk[i]) begin
                    m_act[i] <= 1'b1;
                    m_t[i] <= 0;
                    m_mode[i] <= enc[i];
                end
`ifdef DES_SCHED_ABORT_EN
            end else if (abrt[i]) begin
                m_act[i] <= 1'b0;
`endif
            end else if (m_t[i] == dv_t(i)) begin
                if (ack[i]) m_act[i] <= 1'b0;
            end else begin
                m_t[i] <= m_t[i] + 1;
            end
        end
    end

    // Per-cycle comparison of every DUT against the model.
    always @(negedge clk) begin
        obs_t e, m;
        bit kp;
        for (int i = 0; i < 3; i++) begin
            e = exp_obs(i, m_act[i], m_t[i], m_mode[i], kp);
            m = '1;
            if (!kp) begin
                m.krev = 1'b0;
                m.ksel = 2'b0;
                m.pidx = 2'b0;
                m.ridx = 8'b0;
            end
            checks++;
            if (((obs[i] ^ e) & m) != '0 || $isunknown(obs[i] & m)) begin
                errors++;
                $display("FAIL cycle dut%0d t=%0d got %h exp %h",
                         i, m_t[i], obs[i] & m, e & m);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, act, exp);
        end
    endtask

    // Start a block on DUT i and run until data_valid.
    task automatic run_blk(
        input int i, input bit e, input bit keep,
        output int lat, output int nr, output int ns,
        output logic [5:0] ks, output logic [2:0] rs
    );
        obs_t o;
        bit got;
        int np;
        blk[i] = 1'b1;
        enc[i] = e;
        lat = -1;
        nr = 0;
        ns = 0;
        ks = '0;
        rs = '0;
        np = 0;
        got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            o = obs[i];
            lat++;
            if (c == 0) begin
                blk[i] = keep;
                enc[i] = ~e;
            end
            if (o.rnd) begin
                nr++;
                if (o.ridx == 8'd0 && np < 3) begin
                    ks[np*2 +: 2] = o.ksel;
                    rs[np] = o.krev;
                    np++;
                end
            end
            if (o.swap) ns++;
            if (o.dv) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL timeout dut%0d got no data_valid exp one", i);
        end
    endtask

    // Hold the result for a while, then acknowledge it.
    task automatic ack_blk(input int i, input int hold);
        repeat (hold) @(negedge clk);
        chk("dv_held", obs[i].dv, 1);
        ack[i] = 1'b1;
        @(negedge clk);
        ack[i] = 1'b0;
        chk("idle_busy", obs[i].busy, 0);
    endtask

    task automatic wait_rnd(input int i, input int r);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (c == 0) blk[i] = 1'b0;
            if (obs[i].rnd && obs[i].ridx == 8'(r)) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_round dut%0d got none exp round %0d", i, r);
        end
    endtask

    initial begin
        int lat, nr, ns;
        logic [5:0] ks;
        logic [2:0] rs;
        n_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            blk[i] = 1'b0;
            enc[i] = 1'b0;
            ack[i] = 1'b0;
`ifdef DES_SCHED_ABORT_EN
            abrt[i] = 1'b0;
`endif
        end
        repeat (3) @(negedge clk);
        chk("rst_dut0", 32'(obs[0]), 0);
        chk("rst_dut1", 32'(obs[1]), 0);
        n_rst = 1'b1;
        @(negedge clk);

        // Single DES, encrypt.
        run_blk(0, 1'b1, 1'b0, lat, nr, ns, ks, rs);
        chk("des_enc_lat", lat, 35);
        chk("des_enc_rounds", nr, 16);
        chk("des_enc_swaps", ns, 0);
        chk("des_enc_krev", rs[0], 0);
        ack_blk(0, 0);

        // Single DES, decrypt.
        run_blk(0, 1'b0, 1'b0, lat, nr, ns, ks, rs);
        chk("des_dec_lat", lat, 35);
        chk("des_dec_krev", rs[0], 1);
        chk("des_dec_ksel", ks[1:0], 0);
        ack_blk(0, 2);

        // 3DES EDE encrypt and decrypt.
        run_blk(1, 1'b1, 1'b0, lat, nr, ns, ks, rs);
        chk("tdes_enc_lat", lat, 101);
        chk("tdes_enc_swaps", ns, 2);
        chk("tdes_enc_rounds", nr, 48);
        chk("tdes_enc_ksel", ks, 6'b10_01_00);
        chk("tdes_enc_krev", rs, 3'b010);
        ack_blk(1, 1);
        run_blk(1, 1'b0, 1'b0, lat, nr, ns, ks, rs);
        chk("tdes_dec_lat", lat, 101);
        chk("tdes_dec_ksel", ks, 6'b00_01_10);
        chk("tdes_dec_krev", rs, 3'b101);
        ack_blk(1, 0);

        // Four rounds with a three-cycle key settle.
        run_blk(2, 1'b1, 1'b0, lat, nr, ns, ks, rs);
        chk("kg3_lat", lat, 19);
        chk("kg3_rounds", nr, 4);
        ack_blk(2, 0);

        // Long DONE with blk_ready high: no restart until acked.
        run_blk(0, 1'b1, 1'b1, lat, nr, ns, ks, rs);
        chk("hold_lat", lat, 35);
        ack_blk(0, 10);
        @(negedge clk);
        chk("restart_load", obs[0].load, 1);
        blk[0] = 1'b0;
        run_blk(0, 1'b0, 1'b0, lat, nr, ns, ks, rs);
        chk("restart_lat", lat, 34);
        ack_blk(0, 0);

        // Async reset in round 7, then a clean block.
        blk[0] = 1'b1;
        enc[0] = 1'b1;
        wait_rnd(0, 7);
        #2 n_rst = 1'b0;
        #1 chk("async_rst_outs", 32'(obs[0]), 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        run_blk(0, 1'b1, 1'b0, lat, nr, ns, ks, rs);
        chk("post_rst_lat", lat, 35);
        chk("post_rst_rounds", nr, 16);
        ack_blk(0, 0);

`ifdef DES_SCHED_ABORT_EN
        // Synchronous abort in round 7, then a clean block.
        blk[0] = 1'b1;
        enc[0] = 1'b1;
        wait_rnd(0, 7);
        abrt[0] = 1'b1;
        @(negedge clk);
        abrt[0] = 1'b0;
        chk("abort_outs", 32'(obs[0]), 0);
        run_blk(0, 1'b1, 1'b0, lat, nr, ns, ks, rs);
        chk("post_abort_lat", lat, 35);
        ack_blk(0, 0);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
